// File: rtl/csc_row_rdr.sv
// rtl/csc_row_rdr.sv - CSC first-row reader: streams every circulant row from one stored first row.
// Optional abort input enabled by defining CSC_RDR_ABORT_EN.
module csc_row_rdr #(
  parameter  int MAT_RANK = 256,
  parameter  int DATA_W   = 32,
  localparam int INDEX_W  = $clog2(MAT_RANK)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_vld,
  output logic                  ld_rdy,
  input  logic [2:0]            ld_nnz,
  input  logic [4*INDEX_W-1:0]  ld_col,
  input  logic [4*DATA_W-1:0]   ld_val_r,
  input  logic [4*DATA_W-1:0]   ld_val_i,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [INDEX_W-1:0]    out_row,
  output logic [INDEX_W-1:0]    out_col,
  output logic [DATA_W-1:0]     out_val_r,
  output logic [DATA_W-1:0]     out_val_i,
  output logic                  out_eor,
  output logic                  out_last
`ifdef CSC_RDR_ABORT_EN
  ,
  input  logic                  abort
`endif
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state_q, state_d;
  logic [2:0]          nnz_q, nnz_d;
  logic [INDEX_W-1:0]  col_q  [0:3];
  logic [INDEX_W-1:0]  col_d  [0:3];
  logic [DATA_W-1:0]   valr_q [0:3];
  logic [DATA_W-1:0]   valr_d [0:3];
  logic [DATA_W-1:0]   vali_q [0:3];
  logic [DATA_W-1:0]   vali_d [0:3];
  logic [INDEX_W-1:0]  r_q, r_d;
  logic [1:0]          k_q, k_d;

  logic                out_vld_q, out_vld_d;
  logic [INDEX_W-1:0]  out_row_q, out_row_d;
  logic [INDEX_W-1:0]  out_col_q, out_col_d;
  logic [DATA_W-1:0]   out_val_r_q, out_val_r_d;
  logic [DATA_W-1:0]   out_val_i_q, out_val_i_d;
  logic                out_eor_q, out_eor_d;
  logic                out_last_q, out_last_d;

  logic                abort_w;
  logic                xfer;
  logic                row_end;
  logic                eor_n;
  logic [1:0]          k_n;
  logic [INDEX_W-1:0]  r_n;
  logic [2:0]          nnz_c;

`ifdef CSC_RDR_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign ld_rdy = rst_n & (state_q == IDLE);
  assign xfer   = out_vld_q & out_rdy;

  always_comb begin
    state_d     = state_q;
    nnz_d       = nnz_q;
    col_d       = col_q;
    valr_d      = valr_q;
    vali_d      = vali_q;
    r_d         = r_q;
    k_d         = k_q;
    out_vld_d   = out_vld_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_val_r_d = out_val_r_q;
    out_val_i_d = out_val_i_q;
    out_eor_d   = out_eor_q;
    out_last_d  = out_last_q;

    nnz_c   = (ld_nnz > 3'd4) ? 3'd4 : ld_nnz;
    // Coordinates of the beat that follows the one currently on the outputs.
    row_end = ({1'b0, k_q} == (nnz_q - 3'd1));
    k_n     = row_end ? 2'd0 : (k_q + 2'd1);
    r_n     = row_end ? (r_q + INDEX_W'(1)) : r_q;
    eor_n   = ({1'b0, k_n} == (nnz_q - 3'd1));

    case (state_q)
      IDLE: begin
        if (ld_vld && ld_rdy) begin
          nnz_d = nnz_c;
          r_d   = '0;
          k_d   = '0;
          for (int i = 0; i < 4; i++) begin
            col_d[i]  = ld_col[i*INDEX_W +: INDEX_W];
            valr_d[i] = ld_val_r[i*DATA_W +: DATA_W];
            vali_d[i] = ld_val_i[i*DATA_W +: DATA_W];
          end
          if (nnz_c != 3'd0) begin
            // First beat comes straight from the load bus so it is valid one cycle later.
            state_d     = STREAM;
            out_vld_d   = 1'b1;
            out_row_d   = '0;
            out_col_d   = ld_col[0 +: INDEX_W];
            out_val_r_d = ld_val_r[0 +: DATA_W];
            out_val_i_d = ld_val_i[0 +: DATA_W];
            out_eor_d   = (nnz_c == 3'd1);
            out_last_d  = 1'b0;
          end
        end
      end

      STREAM: begin
        if (abort_w || (xfer && out_last_q)) begin
          state_d     = IDLE;
          out_vld_d   = 1'b0;
          out_row_d   = '0;
          out_col_d   = '0;
          out_val_r_d = '0;
          out_val_i_d = '0;
          out_eor_d   = 1'b0;
          out_last_d  = 1'b0;
        end else if (xfer) begin
          k_d         = k_n;
          r_d         = r_n;
          out_row_d   = r_n;
          out_col_d   = col_q[k_n] + r_n;
          out_val_r_d = valr_q[k_n];
          out_val_i_d = vali_q[k_n];
          out_eor_d   = eor_n;
          out_last_d  = eor_n && (r_n == INDEX_W'(MAT_RANK - 1));
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      nnz_q       <= '0;
      r_q         <= '0;
      k_q         <= '0;
      out_vld_q   <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_val_r_q <= '0;
      out_val_i_q <= '0;
      out_eor_q   <= 1'b0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        col_q[i]  <= '0;
        valr_q[i] <= '0;
        vali_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      nnz_q       <= nnz_d;
      r_q         <= r_d;
      k_q         <= k_d;
      out_vld_q   <= out_vld_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_val_r_q <= out_val_r_d;
      out_val_i_q <= out_val_i_d;
      out_eor_q   <= out_eor_d;
      out_last_q  <= out_last_d;
      for (int i = 0; i < 4; i++) begin
        col_q[i]  <= col_d[i];
        valr_q[i] <= valr_d[i];
        vali_q[i] <= vali_d[i];
      end
    end
  end

  assign out_vld   = out_vld_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_val_r = out_val_r_q;
  assign out_val_i = out_val_i_q;
  assign out_eor   = out_eor_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_csc_row_rdr.sv
// tb/tb_csc_row_rdr.sv - self-checking bench for csc_row_rdr (MAT_RANK=8, DATA_W=32).
module tb_csc_row_rdr;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ld_vld = 1'b0;
  logic            ld_rdy;
  logic [2:0]      ld_nnz = '0;
  logic [4*IW-1:0] ld_col = '0;
  logic [4*DW-1:0] ld_val_r = '0;
  logic [4*DW-1:0] ld_val_i = '0;
  logic            out_vld;
  logic            out_rdy = 1'b1;
  logic [IW-1:0]   out_row;
  logic [IW-1:0]   out_col;
  logic [DW-1:0]   out_val_r;
  logic [DW-1:0]   out_val_i;
  logic            out_eor;
  logic            out_last;
`ifdef CSC_RDR_ABORT_EN
  logic            abort = 1'b0;
`endif

  csc_row_rdr #(.MAT_RANK(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_nnz(ld_nnz), .ld_col(ld_col),
    .ld_val_r(ld_val_r), .ld_val_i(ld_val_i),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_row(out_row), .out_col(out_col),
    .out_val_r(out_val_r), .out_val_i(out_val_i), .out_eor(out_eor), .out_last(out_last)
`ifdef CSC_RDR_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          row;
    int          col;
    logic [31:0] vr;
    logic [31:0] vi;
    bit          eor;
    bit          last;
  } beat_t;

  beat_t exp_q[$];
  beat_t log_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    last_cyc = -100;
  int    gap = 0;
  int    accepts = 0;
  bit    bp = 1'b0;
  logic  rst_s = 1'b0;

  always @(posedge clk) rst_s <= rst_n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference stream: row-major walk, columns shifted cyclically by the row index.
  task automatic model_load();
    int    n;
    beat_t b;
    n = (ld_nnz > 3'd4) ? 4 : int'(ld_nnz);
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < n; k++) begin
        b.row  = r;
        b.col  = (int'(ld_col[k*IW +: IW]) + r) % N;
        b.vr   = ld_val_r[k*DW +: DW];
        b.vi   = ld_val_i[k*DW +: DW];
        b.eor  = (k == n - 1);
        b.last = (k == n - 1) && (r == N - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  always @(negedge clk) begin
    bit    idle;
    bit    abort_now;
    beat_t e;
    beat_t a;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      if (!rst_s) begin
        chk("rst_out_vld", 64'(out_vld), 64'(0));
        chk("rst_ld_rdy", 64'(ld_rdy), 64'(0));
      end
    end else begin
      idle = (exp_q.size() == 0);
      chk("ld_rdy", 64'(ld_rdy), 64'(idle));
      if (idle) begin
        chk("out_vld_idle", 64'(out_vld), 64'(0));
      end else begin
        e = exp_q[0];
        chk("out_vld", 64'(out_vld), 64'(1));
        chk("out_row", 64'(out_row), 64'(e.row));
        chk("out_col", 64'(out_col), 64'(e.col));
        chk("out_val_r", 64'(out_val_r), 64'(e.vr));
        chk("out_val_i", 64'(out_val_i), 64'(e.vi));
        chk("out_eor", 64'(out_eor), 64'(e.eor));
        chk("out_last", 64'(out_last), 64'(e.last));
        abort_now = 1'b0;
`ifdef CSC_RDR_ABORT_EN
        abort_now = abort;
`endif
        if (abort_now) begin
          exp_q.delete();
        end else if (out_rdy) begin
          a.row = int'(out_row); a.col = int'(out_col);
          a.vr = out_val_r; a.vi = out_val_i;
          a.eor = out_eor; a.last = out_last;
          log_q.push_back(a);
          if (e.last) last_cyc = cyc;
          void'(exp_q.pop_front());
        end
      end
      if (idle && ld_vld) begin
        accepts++;
        gap = cyc - last_cyc;
        model_load();
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_rdy = bp ? ~out_rdy : 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input int n, input int c0, input int c1, input int c2, input int c3);
    ld_nnz = 3'(n);
    ld_col = {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    for (int k = 0; k < 4; k++) begin
      ld_val_r[k*DW +: DW] = 32'(k + 1);
      ld_val_i[k*DW +: DW] = 32'(-(k + 1));
    end
    ld_vld = 1'b1;
  endtask

  task automatic wait_accept(input int limit);
    int a0;
    int t;
    a0 = accepts;
    t = 0;
    while (accepts == a0 && t < limit) begin
      step();
      t++;
    end
    chk("accept_timeout", 64'(accepts != a0), 64'(1));
  endtask

  task automatic load(input int n, input int c0, input int c1, input int c2, input int c3);
    drive_load(n, c0, c1, c2, c3);
    wait_accept(50);
    ld_vld = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_vld) && t < limit) begin
      step();
      t++;
    end
    chk("done_timeout", 64'(exp_q.size() == 0 && !out_vld), 64'(1));
  endtask

  initial begin
    int t;
    int bad;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("reset_ld_rdy", 64'(ld_rdy), 64'(1));
    chk("reset_out_vld", 64'(out_vld), 64'(0));

    // 1: four entries, no backpressure
    log_q.delete();
    load(4, 1, 3, 5, 7);
    wait_done(200);
    chk("t1_ld_rdy_after", 64'(ld_rdy), 64'(1));
    chk("t1_count", 64'(log_q.size()), 64'(32));
    chk("t1_b0_col", 64'(log_q[0].col), 64'(1));
    chk("t1_b4_row", 64'(log_q[4].row), 64'(1));
    chk("t1_b4_col", 64'(log_q[4].col), 64'(2));
    chk("t1_b7_col", 64'(log_q[7].col), 64'(0));
    chk("t1_b28_col", 64'(log_q[28].col), 64'(0));
    chk("t1_b31_col", 64'(log_q[31].col), 64'(6));
    chk("t1_b31_last", 64'(log_q[31].last), 64'(1));
    chk("t1_b30_last", 64'(log_q[30].last), 64'(0));
    chk("t1_b3_eor", 64'(log_q[3].eor), 64'(1));
    chk("t1_b2_eor", 64'(log_q[2].eor), 64'(0));
    chk("t1_b2_vr", 64'(log_q[2].vr), 64'(32'd3));
    chk("t1_b2_vi", 64'(log_q[2].vi), 64'(32'hFFFF_FFFD));

    // 2: two entries
    log_q.delete();
    load(2, 2, 6, 0, 0);
    wait_done(200);
    chk("t2_count", 64'(log_q.size()), 64'(16));
    chk("t2_b6_row", 64'(log_q[6].row), 64'(3));
    chk("t2_b6_col", 64'(log_q[6].col), 64'(5));
    chk("t2_b7_col", 64'(log_q[7].col), 64'(1));
    chk("t2_b7_eor", 64'(log_q[7].eor), 64'(1));
    chk("t2_b6_eor", 64'(log_q[6].eor), 64'(0));

    // 3: backpressure with out_rdy toggling
    log_q.delete();
    bp = 1'b1;
    load(4, 1, 3, 5, 7);
    wait_done(400);
    bp = 1'b0;
    chk("t3_count", 64'(log_q.size()), 64'(32));
    bad = 0;
    for (int i = 0; i < log_q.size(); i++)
      if (log_q[i].col != (1 + 2 * (i % 4) + i / 4) % N || log_q[i].row != i / 4) bad++;
    chk("t3_order", 64'(bad), 64'(0));

    // 4: load held valid while streaming
    log_q.delete();
    drive_load(2, 2, 6, 0, 0);
    wait_accept(50);
    drive_load(2, 0, 4, 0, 0);
    wait_accept(100);
    ld_vld = 1'b0;
    wait_done(200);
    chk("t4_accept_gap", 64'(gap), 64'(1));
    chk("t4_count", 64'(log_q.size()), 64'(32));
    chk("t4_b15_last", 64'(log_q[15].last), 64'(1));
    chk("t4_b16_col", 64'(log_q[16].col), 64'(0));
    chk("t4_b16_row", 64'(log_q[16].row), 64'(0));

    // clamp: nnz above 4 behaves as 4
    log_q.delete();
    load(7, 1, 3, 5, 7);
    wait_done(200);
    chk("clamp_count", 64'(log_q.size()), 64'(32));

    // 5: reset mid-stream, then zero-count load
    log_q.delete();
    load(4, 1, 3, 5, 7);
    t = 0;
    while (log_q.size() < 10 && t < 100) begin
      step();
      t++;
    end
    chk("t5_reach10", 64'(log_q.size()), 64'(10));
    rst_n = 1'b0;
    step();
    chk("t5_rst_vld", 64'(out_vld), 64'(0));
    chk("t5_rst_rdy", 64'(ld_rdy), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("t5_rel_rdy", 64'(ld_rdy), 64'(1));
    step();
    chk("t5_count", 64'(log_q.size()), 64'(10));
    drive_load(0, 1, 3, 5, 7);
    repeat (5) step();
    ld_vld = 1'b0;
    step();
    chk("t5_zero_count", 64'(log_q.size()), 64'(10));
    chk("t5_zero_rdy", 64'(ld_rdy), 64'(1));
    chk("t5_zero_vld", 64'(out_vld), 64'(0));

`ifdef CSC_RDR_ABORT_EN
    // 6: abort on beat 5
    log_q.delete();
    load(4, 1, 3, 5, 7);
    t = 0;
    while (log_q.size() < 4 && t < 100) begin
      step();
      t++;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t6_abort_vld", 64'(out_vld), 64'(0));
    chk("t6_abort_rdy", 64'(ld_rdy), 64'(1));
    chk("t6_abort_count", 64'(log_q.size()), 64'(4));
    log_q.delete();
    load(4, 1, 3, 5, 7);
    wait_done(200);
    chk("t6_count", 64'(log_q.size()), 64'(32));
    chk("t6_b0_row", 64'(log_q[0].row), 64'(0));
    chk("t6_b0_col", 64'(log_q[0].col), 64'(1));
`endif

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csc_row_rdr.md
Name: csc_row_rdr

Overview:
- Reader side of the CSC first-row store. It accepts one packed first row of the sparse circulant matrix: up to 4 nonzero complex values plus their column indices.
- It then streams every row of the matrix, element by element, over a valid/ready interface. Row r reuses the first-row values, with each column shifted cyclically by r.
- It sits between the first-row generator and the downstream sparse matrix-vector multiplier.

Parameters:
- MAT_RANK, 256, matrix rank N; must be a power of 2 and at least 2. INDEX_W = clog2(MAT_RANK).
- DATA_W, 32, width of the real and imaginary parts of each value.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ld_vld  in  1  first-row load valid
- ld_rdy  out  1  ready to accept a load
- ld_nnz  in  3  number of nonzeros in the first row (0..4)
- ld_col  in  4*INDEX_W  column index of entry k in bits [k*INDEX_W +: INDEX_W]
- ld_val_r  in  4*DATA_W  real part of entry k
- ld_val_i  in  4*DATA_W  imaginary part of entry k
- out_vld  out  1  element valid
- out_rdy  in  1  downstream ready
- out_row  out  INDEX_W  row index of the current element
- out_col  out  INDEX_W  column index of the current element
- out_val_r  out  DATA_W  real part
- out_val_i  out  DATA_W  imaginary part
- out_eor  out  1  last element of the current row
- out_last  out  1  last element of the whole matrix

Behaviour:
- Clocking and reset: single clk; reset is synchronous, active-low on rst_n.
- While rst_n=0, all registers clear on the next edge: state=IDLE, all out_* = 0, ld_rdy = 0. After release, ld_rdy = 1 in IDLE.
- FSM states: IDLE, STREAM.
- ld_rdy = 1 only in IDLE, and never while rst_n=0.
- Load handshake: a load is accepted on an edge where ld_vld & ld_rdy. On that edge the block captures ld_nnz, ld_col, ld_val_r and ld_val_i, and sets the row counter and entry counter to 0.
- ld_nnz values above 4 are clamped to 4.
- If ld_nnz = 0: stay in IDLE, emit nothing. ld_rdy stays 1.
- Otherwise go to STREAM. out_vld rises in the cycle after the accepting edge (latency 1).
- Stream order: for r = 0..MAT_RANK-1, for k = 0..nnz-1, one beat per element.
  - out_row = r.
  - out_col = (col_k + r) mod MAT_RANK, computed as an INDEX_W-bit truncated add.
  - out_val_r and out_val_i = entry k.
  - Column order within a row is storage order; the block does not re-sort after wrap.
- Output handshake: a beat transfers on an edge where out_vld & out_rdy.
  - While out_vld=1 and out_rdy=0, all out_* signals hold stable.
  - out_vld never drops without a transfer, except on reset or abort.
- All out_* signals are registered.
  - out_eor = 1 when k = nnz-1.
  - out_last = 1 when out_eor = 1 and r = MAT_RANK-1.
- Counter advance on a transfer:
  - k increments.
  - At k = nnz-1: k returns to 0 and r increments.
  - On the transfer of the out_last beat: go to IDLE and drive out_vld = 0 next cycle. ld_rdy = 1 in that cycle, so the next load can be accepted one cycle after the last transfer.
- Total beats per load: nnz * MAT_RANK. Back-to-back transfers sustain one beat per cycle.
- ld_vld during STREAM is ignored because ld_rdy = 0. The captured load registers do not change.
- Reset asserted mid-stream: the stream is discarded. out_vld = 0 on the next edge, state returns to IDLE, and no partial completion is signalled.

Optional Feature:
- Macro: CSC_RDR_ABORT_EN.
- When defined: adds input port abort (1 bit). If abort = 1 on an edge in STREAM, the block goes to IDLE and out_* clear to 0 on that edge. Any beat handshaking in the same cycle is dropped. abort in IDLE has no effect.
- When not defined: no abort port; a stream can only end via the out_last transfer or reset.

Test Plan (MAT_RANK=8, DATA_W=32):
1. Four-entry load, no backpressure.
   - Stimulus: ld_nnz=4, cols {1,3,5,7}, vals (k+1, -(k+1)); out_rdy=1.
   - Response: 32 beats, first beat one cycle after load.
   - Row 0 cols 1,3,5,7; row 1 cols 2,4,6,0; row 7 cols 0,2,4,6.
   - out_eor on every 4th beat; out_last only on beat 32 (row 7, col 6); ld_rdy = 1 the next cycle.
2. Two-entry load.
   - Stimulus: ld_nnz=2, cols {2,6}.
   - Response: 16 beats; row 3 emits cols 5,1; out_eor on every 2nd beat.
3. Backpressure.
   - Stimulus: case 1 with out_rdy toggling 1,0,1,0,...
   - Response: exactly 32 transfers, none duplicated or skipped; outputs stable during every stalled cycle.
4. Load during streaming.
   - Stimulus: ld_vld held high throughout case 2 with new cols {0,4}.
   - Response: ld_rdy stays 0 until the last transfer; the new load is accepted one cycle after it; first new beat is col 0.
5. Reset mid-stream and zero-count load.
   - Stimulus: rst_n=0 after beat 10 of case 1.
   - Response: out_vld = 0 next edge; ld_rdy = 1 after release.
   - Stimulus: a load with ld_nnz=0.
   - Response: no beats; ld_rdy stays 1.
6. Abort (only with CSC_RDR_ABORT_EN).
   - Stimulus: abort pulse at beat 5 of case 1.
   - Response: out_vld = 0 next cycle; IDLE; the next load streams normally from row 0.
